// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage and the control unit:
// opcode and funct encodings, the fetch FSM state type and the default
// reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Jump beats branch; a taken branch needs both branch and zero.
// Only the low 26 instruction bits are needed (jump target and
// branch immediate), so only those are brought in.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       instr_low,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] jump_target;

  // Sequential PC, sign-extended word branch offset and pseudo-direct jump target
  always_comb begin
    pc_plus4      = pc + ADDR_W'(4);
    branch_offset = {{(ADDR_W-18){instr_low[15]}}, instr_low[15:0], 2'b00};
    jump_target   = {pc_plus4[ADDR_W-1:28], instr_low, 2'b00};
  end

  // Priority select: jump, then taken branch, then fall through
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction
// over a req/ack handshake, presents it to decode until retired, then
// steps the PC using the resolved branch/jump/zero signals.
// Optional macro FETCH_PERF_CNT_EN adds retired and stall counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic              imem_ack_in,
  input  logic [31:0]       imem_rdata_in,
  output logic              instr_valid_out,
  output logic [31:0]       instr_out,
  output logic [5:0]        op_out,
  output logic [5:0]        func_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4_out,
  input  logic              retire_in,
  input  logic              branch_in,
  input  logic              jump_in,
  input  logic              zero_in
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt_out,
  output logic [31:0]       stall_cnt_out
`endif
);

  fetch_state_t      state;
  fetch_state_t      next_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       instr;
  logic              fetch_done;
  logic              retire_fire;

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc_calc (
    .pc        (pc),
    .instr_low (instr[25:0]),
    .branch    (branch_in),
    .jump      (jump_in),
    .zero      (zero_in),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  assign fetch_done  = (state == FETCH) && imem_ack_in;
  assign retire_fire = (state == HOLD) && retire_in;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and handshake outputs; IDLE always lasts one cycle so a stale ack is dropped
  always_comb begin
    next_state      = state;
    imem_req_out    = 1'b0;
    instr_valid_out = 1'b0;
    case (state)
      IDLE: begin
        next_state = FETCH;
      end
      FETCH: begin
        imem_req_out = 1'b1;
        if (imem_ack_in) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        instr_valid_out = 1'b1;
        if (retire_in) begin
          next_state = FETCH;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // PC only advances when the held instruction retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (retire_fire) begin
      pc <= next_pc;
    end
  end

  // Capture the instruction word on the accepting ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= 32'h0000_0000;
    end else if (fetch_done) begin
      instr <= imem_rdata_in;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running wrap-around counters of retirements and unacknowledged fetch cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_out <= 32'd0;
      stall_cnt_out   <= 32'd0;
    end else begin
      if (retire_fire) begin
        retired_cnt_out <= retired_cnt_out + 32'd1;
      end
      if ((state == FETCH) && !imem_ack_in) begin
        stall_cnt_out <= stall_cnt_out + 32'd1;
      end
    end
  end
`endif

  assign imem_addr_out = pc;
  assign instr_out     = instr;
  assign op_out        = instr[31:26];
  assign func_out      = instr[5:0];
  assign pc_out        = pc;
  assign pc_plus4_out  = pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Two instances share all inputs:
// dut_a uses the default reset PC, dut_b starts at 32'h1000_0040 so the
// jump path can be exercised in the upper address region.
// Honours FETCH_PERF_CNT_EN for the counter checks.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic        retire_in;
  logic        branch_in;
  logic        jump_in;
  logic        zero_in;

  logic        req_a, valid_a, req_b, valid_b;
  logic [31:0] addr_a, instr_a, pc_a, pc4_a;
  logic [31:0] addr_b, instr_b, pc_b, pc4_b;
  logic [5:0]  op_a, func_a, op_b, func_b;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_a, stall_a, retired_b, stall_b;
`endif

  int total = 0;
  int bad   = 0;

  instr_fetch_unit dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_out    (req_a),
    .imem_addr_out   (addr_a),
    .imem_ack_in     (imem_ack_in),
    .imem_rdata_in   (imem_rdata_in),
    .instr_valid_out (valid_a),
    .instr_out       (instr_a),
    .op_out          (op_a),
    .func_out        (func_a),
    .pc_out          (pc_a),
    .pc_plus4_out    (pc4_a),
    .retire_in       (retire_in),
    .branch_in       (branch_in),
    .jump_in         (jump_in),
    .zero_in         (zero_in)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt_out (retired_a),
    .stall_cnt_out   (stall_a)
`endif
  );

  instr_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h1000_0040)
  ) dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_out    (req_b),
    .imem_addr_out   (addr_b),
    .imem_ack_in     (imem_ack_in),
    .imem_rdata_in   (imem_rdata_in),
    .instr_valid_out (valid_b),
    .instr_out       (instr_b),
    .op_out          (op_b),
    .func_out        (func_b),
    .pc_out          (pc_b),
    .pc_plus4_out    (pc4_b),
    .retire_in       (retire_in),
    .branch_in       (branch_in),
    .jump_in         (jump_in),
    .zero_in         (zero_in)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt_out (retired_b),
    .stall_cnt_out   (stall_b)
`endif
  );

  // free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // drive one cycle's inputs, take the clock edge, settle just after it
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic ret, input logic br,
                               input logic jmp, input logic zr);
    imem_ack_in   = ack;
    imem_rdata_in = rdata;
    retire_in     = ret;
    branch_in     = br;
    jump_in       = jmp;
    zero_in       = zr;
    @(posedge clk);
    #1;
  endtask

  // zero-wait fetch of one word on dut_a, then retire it with the given flags
  task automatic fetchRetire(input string tag, input logic [31:0] exp_pc,
                             input logic [31:0] word, input logic br,
                             input logic jmp, input logic zr,
                             input logic [31:0] exp_next);
    applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_valid"}, {31'd0, valid_a}, 32'd1);
    checkOutput({tag, "_pc"}, pc_a, exp_pc);
    applyStimulus(1'b0, 32'd0, 1'b1, br, jmp, zr);
    checkOutput({tag, "_next"}, addr_a, exp_next);
  endtask

  localparam logic [31:0] W_ADDI   = 32'h2008_0005;
  localparam logic [31:0] W_BEQ_P2 = 32'h1022_0002;
  localparam logic [31:0] W_BEQ_M4 = 32'h1022_FFFC;
  localparam logic [31:0] W_BEQ_M7 = 32'h1022_FFF9;
  localparam logic [31:0] W_ADD    = 32'h0122_4020;
  localparam logic [31:0] W_J      = 32'h0800_0100;

  initial begin
    rst_n         = 1'b0;
    imem_ack_in   = 1'b0;
    imem_rdata_in = 32'd0;
    retire_in     = 1'b0;
    branch_in     = 1'b0;
    jump_in       = 1'b0;
    zero_in       = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    checkOutput("rst_req", {31'd0, req_a}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid_a}, 32'd0);
    checkOutput("rst_instr", instr_a, 32'd0);
    checkOutput("rst_pc", pc_a, 32'd0);
    checkOutput("rst_pc_b", pc_b, 32'h1000_0040);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("rst_retired", retired_a, 32'd0);
    checkOutput("rst_stall", stall_a, 32'd0);
`endif

    // zero-wait ADDI fetch; ack already high during IDLE
    rst_n = 1'b1;
    applyStimulus(1'b1, W_ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_req", {31'd0, req_a}, 32'd1);
    checkOutput("t1_addr", addr_a, 32'd0);
    checkOutput("t1_valid_idle", {31'd0, valid_a}, 32'd0);
    applyStimulus(1'b1, W_ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_valid", {31'd0, valid_a}, 32'd1);
    checkOutput("t1_req_hold", {31'd0, req_a}, 32'd0);
    checkOutput("t1_op", {26'd0, op_a}, 32'h08);
    checkOutput("t1_func", {26'd0, func_a}, 32'h05);
    checkOutput("t1_pc", pc_a, 32'd0);
    checkOutput("t1_pc4", pc4_a, 32'd4);
    checkOutput("t1_instr", instr_a, W_ADDI);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_next", addr_a, 32'd4);
    checkOutput("t1_valid_drop", {31'd0, valid_a}, 32'd0);
    checkOutput("t1_req_again", {31'd0, req_a}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("t1_retired", retired_a, 32'd1);
`endif

    // memory ack delayed three cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t2_req", {31'd0, req_a}, 32'd1);
      checkOutput("t2_addr", addr_a, 32'd4);
      checkOutput("t2_valid", {31'd0, valid_a}, 32'd0);
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput("t2_stall", stall_a, 32'd3);
`endif

    // branches: forward to 0x10, back to 0x04, not-taken, then back to 0xFFFF_FFFC
    fetchRetire("t3_fwd", 32'h4, W_BEQ_P2, 1'b1, 1'b0, 1'b1, 32'h10);
    fetchRetire("t3_back", 32'h10, W_BEQ_M4, 1'b1, 1'b0, 1'b1, 32'h04);
    fetchRetire("t3_fwd2", 32'h4, W_BEQ_P2, 1'b1, 1'b0, 1'b1, 32'h10);
    fetchRetire("t3_nz", 32'h10, W_BEQ_M4, 1'b1, 1'b0, 1'b0, 32'h14);
    fetchRetire("t3_top", 32'h14, W_BEQ_M7, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);

    // retire during FETCH is ignored, then ADD at the top wraps to 0
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_retire_fetch_req", {31'd0, req_a}, 32'd1);
    checkOutput("t6_retire_fetch_addr", addr_a, 32'hFFFF_FFFC);
    applyStimulus(1'b1, W_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_func", {26'd0, func_a}, 32'h20);
    checkOutput("t6_op", {26'd0, op_a}, 32'h00);
    checkOutput("t6_pc4_wrap", pc4_a, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_next_wrap", addr_a, 32'd0);

    // reset in the middle of a fetch, stale ack during IDLE
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_req_drop", {31'd0, req_a}, 32'd0);
    checkOutput("t5_req_drop_b", {31'd0, req_b}, 32'd0);
    @(posedge clk);
    #1;
    imem_ack_in   = 1'b1;
    imem_rdata_in = 32'hDEAD_BEEF;
    rst_n         = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_req", {31'd0, req_a}, 32'd1);
    checkOutput("t5_addr", addr_a, 32'd0);
    checkOutput("t5_addr_b", addr_b, 32'h1000_0040);
    checkOutput("t5_instr", instr_a, 32'd0);
    checkOutput("t5_valid", {31'd0, valid_a}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_instr_still", instr_a, 32'd0);

    // jump from 0x1000_0040 (dut_b) and from 0 (dut_a)
    applyStimulus(1'b1, W_J, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_pc_b", pc_b, 32'h1000_0040);
    checkOutput("t4_op_b", {26'd0, op_b}, 32'h02);
    checkOutput("t4_valid_b", {31'd0, valid_b}, 32'd1);
    applyStimulus(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_hold_valid", {31'd0, valid_b}, 32'd1);
    checkOutput("t4_hold_instr", instr_b, W_J);
    checkOutput("t4_hold_req", {31'd0, req_b}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_jump_b", addr_b, 32'h1000_0400);
    checkOutput("t4_jump_a", addr_a, 32'h0000_0400);
    applyStimulus(1'b1, W_J, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_pc4_b", pc4_b, 32'h1000_0404);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_jump_wins_b", addr_b, 32'h1000_0400);
    checkOutput("t4_jump_wins_a", addr_a, 32'h0000_0400);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("t4_retired", retired_a, 32'd2);
    checkOutput("t4_stall", stall_a, 32'd1);
    checkOutput("t4_retired_b", retired_b, 32'd2);
    checkOutput("t4_stall_b", stall_b, 32'd1);
`endif

    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // guard against a stuck run
  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
